alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 104 ++++++++++
 tb/tb_alu_op_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Accepts a 4-bit opcode, drives a one-hot mux select for 1 or MULTI_CYCLES
// cycles, then writes the mux result into acc. Optional ACC_FLAGS_EN adds flags.
module alu_op_sequencer #(
  parameter int bus_size     = 16,
  parameter int MULTI_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [3:0]          opcode,
  input  logic                acc_clr,
  input  logic [bus_size-1:0] mux_b,
  output logic [15:0]         sel,
  output logic [bus_size-1:0] acc,
  output logic                busy,
`ifdef ACC_FLAGS_EN
  output logic                zero_flag,
  output logic                neg_flag,
`endif
  output logic                done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  localparam logic [3:0] MC = 4'(MULTI_CYCLES);

  logic [1:0] state;
  logic [3:0] cnt;
  logic [3:0] opcodeReg;
  logic       accept;
  logic       lastExec;

  assign op_ready = (state == IDLE);
  assign busy     = (state == EXEC) || (state == WB);
  assign done     = (state == WB);
  assign accept   = op_valid && op_ready;
  assign lastExec = (state == EXEC) && (cnt <= 4'd1);

  // Select is a pure decode of state so reset forces it low at once
  always_comb begin
    sel = 16'h0000;
    if (state == EXEC) sel = 16'h0001 << opcodeReg;
  end

  // Sequencer FSM with EXEC length down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      opcodeReg <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opcodeReg <= opcode;
            cnt       <= (opcode >= 4'd12) ? MC : 4'd1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (lastExec) begin
            cnt   <= 4'd0;
            state <= WB;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Accumulator: clear beats write-back, mux_b only sampled on last EXEC edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (lastExec) begin
      acc <= mux_b;
    end
  end

`ifdef ACC_FLAGS_EN
  // Flags track acc in the same edge so they never lag the value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b1;
      neg_flag  <= 1'b0;
    end else if (acc_clr) begin
      zero_flag <= 1'b1;
      neg_flag  <= 1'b0;
    end else if (lastExec) begin
      zero_flag <= (mux_b == '0);
      neg_flag  <= mux_b[bus_size-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Table-driven bench for alu_op_sequencer with a write-back scoreboard.
// Corner cases (reset mid-EXEC, idle clear) are hand-written sequences.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  opcode;
  logic        acc_clr;
  logic [15:0] mux_b;
  logic [15:0] sel;
  logic [15:0] acc;
  logic        busy;
  logic        done;
`ifdef ACC_FLAGS_EN
  logic        zero_flag;
  logic        neg_flag;
`endif

  int nCmp = 0;
  int nErr = 0;
  logic [15:0] sbQ[$];

  always #5 clk = ~clk;

  alu_op_sequencer #(.bus_size(16), .MULTI_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .opcode   (opcode),
    .acc_clr  (acc_clr),
    .mux_b    (mux_b),
    .sel      (sel),
    .acc      (acc),
    .busy     (busy),
`ifdef ACC_FLAGS_EN
    .zero_flag(zero_flag),
    .neg_flag (neg_flag),
`endif
    .done     (done)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] data;
    logic        clr;
    logic        hold;
    logic [15:0] expAcc;
    int          expLen;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: each done cycle pops the expected write-back value
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sbQ.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [15:0] e;
        e = sbQ.pop_front();
        chk("acc_wb", 32'(acc), 32'(e));
`ifdef ACC_FLAGS_EN
        chk("zero_flag_wb", 32'(zero_flag), 32'(e == 16'h0));
        chk("neg_flag_wb", 32'(neg_flag), 32'(e[15]));
`endif
      end
    end
  end

  // Caller is at a negedge; returns at the negedge of the following IDLE cycle
  task automatic runOp(input vec_t v);
    int guard = 0;
    int selN = 0;
    int busyN = 0;
    while (op_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    opcode   = v.op;
    mux_b    = 16'($urandom);
    sbQ.push_back(v.expAcc);
    @(negedge clk);
    if (v.hold) opcode = 4'd5;
    else op_valid = 1'b0;
    for (int i = 1; i <= v.expLen; i++) begin
      chk("sel_exec", 32'(sel), 32'(16'h0001 << v.op));
      chk("ready_exec", 32'(op_ready), 32'd0);
      if (sel != 16'h0) selN++;
      if (busy) busyN++;
      mux_b   = (i == v.expLen) ? v.data : 16'($urandom);
      acc_clr = (i == v.expLen) && v.clr;
      @(negedge clk);
    end
    acc_clr = 1'b0;
    mux_b   = 16'($urandom);
    chk("sel_wb", 32'(sel), 32'd0);
    chk("done_wb", 32'(done), 32'd1);
    if (busy) busyN++;
    @(negedge clk);
    chk("sel_count", 32'(selN), 32'(v.expLen));
    chk("busy_count", 32'(busyN), 32'(v.expLen + 1));
    chk("ready_back", 32'(op_ready), 32'd1);
    chk("done_idle", 32'(done), 32'd0);
    chk("acc_hold", 32'(acc), 32'(v.expAcc));
  endtask

  initial begin
    vecs[0] = '{4'd3,  16'h0080, 1'b0, 1'b0, 16'h0080, 1};
    vecs[1] = '{4'd15, 16'h0002, 1'b0, 1'b0, 16'h0002, 4};
    vecs[2] = '{4'd12, 16'h8000, 1'b0, 1'b0, 16'h8000, 4};
    vecs[3] = '{4'd0,  16'h1234, 1'b0, 1'b0, 16'h1234, 1};
    vecs[4] = '{4'd11, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1};
    vecs[5] = '{4'd13, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 4};
    vecs[6] = '{4'd7,  16'h0000, 1'b0, 1'b0, 16'h0000, 1};
    vecs[7] = '{4'd2,  16'hA5A5, 1'b0, 1'b1, 16'hA5A5, 1};
    vecs[8] = '{4'd5,  16'h4321, 1'b0, 1'b0, 16'h4321, 1};

    rst_n    = 1'b0;
    op_valid = 1'b0;
    opcode   = 4'd0;
    acc_clr  = 1'b0;
    mux_b    = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(op_ready), 32'd1);
`ifdef ACC_FLAGS_EN
    chk("rst_zero", 32'(zero_flag), 32'd1);
    chk("rst_neg", 32'(neg_flag), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) runOp(vecs[i]);

    // acc_clr while idle clears acc without starting anything
    chk("pre_clr_acc", 32'(acc), 32'h4321);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    chk("idle_clr_acc", 32'(acc), 32'd0);
    chk("idle_clr_busy", 32'(busy), 32'd0);
`ifdef ACC_FLAGS_EN
    chk("idle_clr_zero", 32'(zero_flag), 32'd1);
`endif

    runOp('{4'd9, 16'h00F0, 1'b0, 1'b0, 16'h00F0, 1});

    // Reset in the 2nd EXEC cycle of opcode 12 aborts the op
    op_valid = 1'b1;
    opcode   = 4'd12;
    mux_b    = 16'hFFFF;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    chk("abort_sel_pre", 32'(sel), 32'h1000);
    rst_n = 1'b0;
    #1;
    chk("abort_sel", 32'(sel), 32'd0);
    chk("abort_acc", 32'(acc), 32'd0);
    chk("abort_ready", 32'(op_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_acc_hold", 32'(acc), 32'd0);
    end

    runOp('{4'd14, 16'h7FFF, 1'b0, 1'b0, 16'h7FFF, 4});

    chk("sb_empty", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
